// File: rtl/bcd_clock_counter_gen_if.sv
// Signal bundle between bcd_clock_counter_gen and its driver; alarm signals
// exist only when BCD_CLOCK_ALARM_EN is defined.
interface bcd_clock_counter_gen_if;
    logic       i_ena;
    logic       i_mode24;
    logic       i_wr;
    logic [1:0] i_sel;
    logic [7:0] i_in;
    logic       o_pm;
    logic [7:0] o_hh;
    logic [7:0] o_mm;
    logic [7:0] o_ss;
    logic       o_mode24;
    logic       o_day;
    logic       o_err;
`ifdef BCD_CLOCK_ALARM_EN
    logic       i_awr;
    logic       i_aen;
    logic       o_alarm;

    modport master (output i_ena, i_mode24, i_wr, i_sel, i_in, i_awr, i_aen,
                    input  o_pm, o_hh, o_mm, o_ss, o_mode24, o_day, o_err, o_alarm);
    modport slave  (input  i_ena, i_mode24, i_wr, i_sel, i_in, i_awr, i_aen,
                    output o_pm, o_hh, o_mm, o_ss, o_mode24, o_day, o_err, o_alarm);
`else
    modport master (output i_ena, i_mode24, i_wr, i_sel, i_in,
                    input  o_pm, o_hh, o_mm, o_ss, o_mode24, o_day, o_err);
    modport slave  (input  i_ena, i_mode24, i_wr, i_sel, i_in,
                    output o_pm, o_hh, o_mm, o_ss, o_mode24, o_day, o_err);
`endif
endinterface

// File: rtl/bcd_clock_counter_gen.sv
// Packed-BCD time-of-day counter with prescaler, runtime 12/24 h mode, checked
// writes and day pulse. Define BCD_CLOCK_ALARM_EN to add the alarm bank.
module bcd_clock_counter_gen #(
    parameter int TICKS_PER_SEC = 1,
    parameter bit MODE24_RST    = 1'b0
) (
    input logic                    i_clk,
    input logic                    i_reset,
    bcd_clock_counter_gen_if.slave bus
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0] HH_RST = MODE24_RST ? 8'h00 : 8'h12;

    // i_ena is a single-cycle strobe with no back-pressure: it is consumed on
    // the edge where it is seen, or dropped when a mode conversion wins.
    logic [PW-1:0] presc, presc_n;
    logic [7:0]    ss, ss_n, mm, mm_n, hh, hh_n;
    logic          pm, pm_n, m24, m24_n, day, day_n, err, err_n;
    logic          fld_ok;
`ifdef BCD_CLOCK_ALARM_EN
    logic [7:0]    a_mm, a_mm_n, a_hh, a_hh_n;
    logic          a_pm, a_pm_n, alarm, alarm_n;
`endif

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [4:0] bcd2bin(input logic [7:0] v);
        return 5'(v[7:4]) * 5'd10 + 5'(v[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [4:0] b);
        if (b >= 5'd20)      return {4'd2, 4'(b - 5'd20)};
        else if (b >= 5'd10) return {4'd1, 4'(b - 5'd10)};
        else                 return {4'd0, 4'(b)};
    endfunction

    function automatic logic [7:0] to24(input logic [7:0] h, input logic p);
        logic [4:0] b;
        b = bcd2bin(h);
        if (b == 5'd12) b = p ? 5'd12 : 5'd0;
        else if (p)     b = b + 5'd12;
        return bin2bcd(b);
    endfunction

    // Returns {pm, hh} in 12 h form.
    function automatic logic [8:0] to12(input logic [7:0] h);
        logic [4:0] b;
        b = bcd2bin(h);
        if (b == 5'd0)       return {1'b0, 8'h12};
        else if (b < 5'd12)  return {1'b0, bin2bcd(b)};
        else if (b == 5'd12) return {1'b1, 8'h12};
        else                 return {1'b1, bin2bcd(b - 5'd12)};
    endfunction

    always_comb begin
        case (bus.i_sel)
            2'b00, 2'b01: fld_ok = bcd_ok(bus.i_in, 8'h00, 8'h59);
            2'b10:        fld_ok = m24 ? bcd_ok(bus.i_in, 8'h00, 8'h23)
                                       : bcd_ok(bus.i_in, 8'h01, 8'h12);
            default:      fld_ok = 1'b1;
        endcase
    end

    always_comb begin
        presc_n = presc;
        ss_n    = ss;
        mm_n    = mm;
        hh_n    = hh;
        pm_n    = pm;
        m24_n   = m24;
        day_n   = 1'b0;
        err_n   = 1'b0;
`ifdef BCD_CLOCK_ALARM_EN
        a_mm_n  = a_mm;
        a_hh_n  = a_hh;
        a_pm_n  = a_pm;
        alarm_n = 1'b0;
`endif
        if (bus.i_mode24 != m24) begin
            m24_n = bus.i_mode24;
            if (bus.i_mode24) begin
                hh_n = to24(hh, pm);
                pm_n = 1'b0;
`ifdef BCD_CLOCK_ALARM_EN
                a_hh_n = to24(a_hh, a_pm);
                a_pm_n = 1'b0;
`endif
            end else begin
                {pm_n, hh_n} = to12(hh);
`ifdef BCD_CLOCK_ALARM_EN
                {a_pm_n, a_hh_n} = to12(a_hh);
`endif
            end
        end else if (bus.i_ena && bus.i_wr) begin
            if (!fld_ok) begin
                err_n = 1'b1;
`ifdef BCD_CLOCK_ALARM_EN
            end else if (bus.i_awr) begin
                case (bus.i_sel)
                    2'b01:   a_mm_n = bus.i_in;
                    2'b10:   a_hh_n = bus.i_in;
                    2'b11:   if (!m24) a_pm_n = bus.i_in[0];
                    default: ;
                endcase
`endif
            end else begin
                case (bus.i_sel)
                    2'b00:   ss_n = bus.i_in;
                    2'b01:   mm_n = bus.i_in;
                    2'b10:   hh_n = bus.i_in;
                    default: if (!m24) pm_n = bus.i_in[0];
                endcase
            end
        end else if (bus.i_ena) begin
            if (presc != PMAX) begin
                presc_n = presc + PW'(1);
            end else begin
                presc_n = '0;
                if (ss != 8'h59) begin
                    ss_n = bcd_inc(ss);
                end else begin
                    ss_n = 8'h00;
                    if (mm != 8'h59) begin
                        mm_n = bcd_inc(mm);
                    end else begin
                        mm_n = 8'h00;
                        if (m24) begin
                            if (hh == 8'h23) begin
                                hh_n  = 8'h00;
                                day_n = 1'b1;
                            end else begin
                                hh_n = bcd_inc(hh);
                            end
                        end else if (hh == 8'h11) begin
                            // 11:59:59 pm -> 12:00:00 am is the only midnight crossing
                            hh_n  = 8'h12;
                            pm_n  = ~pm;
                            day_n = pm;
                        end else if (hh == 8'h12) begin
                            hh_n = 8'h01;
                        end else begin
                            hh_n = bcd_inc(hh);
                        end
                    end
                end
`ifdef BCD_CLOCK_ALARM_EN
                alarm_n = bus.i_aen && (ss_n == 8'h00) && (hh_n == a_hh) &&
                          (mm_n == a_mm) && (pm_n == a_pm);
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc <= '0;
            ss    <= 8'h00;
            mm    <= 8'h00;
            hh    <= HH_RST;
            pm    <= 1'b0;
            m24   <= MODE24_RST;
            day   <= 1'b0;
            err   <= 1'b0;
`ifdef BCD_CLOCK_ALARM_EN
            a_mm  <= 8'h00;
            a_hh  <= HH_RST;
            a_pm  <= 1'b0;
            alarm <= 1'b0;
`endif
        end else begin
            presc <= presc_n;
            ss    <= ss_n;
            mm    <= mm_n;
            hh    <= hh_n;
            pm    <= pm_n;
            m24   <= m24_n;
            day   <= day_n;
            err   <= err_n;
`ifdef BCD_CLOCK_ALARM_EN
            a_mm  <= a_mm_n;
            a_hh  <= a_hh_n;
            a_pm  <= a_pm_n;
            alarm <= alarm_n;
`endif
        end
    end

    assign bus.o_ss     = ss;
    assign bus.o_mm     = mm;
    assign bus.o_hh     = hh;
    assign bus.o_pm     = pm & ~m24;
    assign bus.o_mode24 = m24;
    assign bus.o_day    = day;
    assign bus.o_err    = err;
`ifdef BCD_CLOCK_ALARM_EN
    assign bus.o_alarm  = alarm;
`endif
endmodule
